// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding initiator on the data memory port, with alignment and range fault detection.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module load_store_unit #(
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic        lsu_store_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_unsigned_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wr_data_i,
  input  logic [4:0]  lsu_rd_idx_i,
  output logic        lsu_done_o,
  output logic [31:0] lsu_load_data_o,
  output logic [4:0]  lsu_rd_idx_o,
  output logic        lsu_rd_we_o,
  output logic        lsu_misalign_o,
  output logic        lsu_range_o,
  output logic        data_mem_req_o,
  output logic [31:0] data_mem_addr_o,
  output logic [1:0]  data_mem_byte_en_o,
  output logic        data_mem_wr_o,
  output logic [31:0] data_mem_wr_data_o,
  output logic        data_mem_zero_extnd_o,
  input  logic [31:0] data_mem_rd_data_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [32:0] ADDR_LIMIT = 33'(DMEM_WORDS) << 2;

  state_t      state, state_nxt;
  logic        store_p0, uns_p0, mis_p0, rng_p0;
  logic [1:0]  size_p0;
  logic [31:0] addr_p0, wr_data_p0;
  logic [4:0]  rd_idx_p0;
  logic [31:0] load_data_p1;

  logic        accept, mis_chk, rng_chk, fault;
  logic [31:0] addr_eff;
  logic        mem_active;

  function automatic logic out_of_range(input logic [1:0] size, input logic [31:0] addr);
    return ({1'b0, addr} >= ADDR_LIMIT) || (size == 2'd2);
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd1:    return lo[0];
      2'd3:    return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  assign mis_chk  = misaligned(lsu_size_i, lsu_addr_i[1:0]);
  assign addr_eff = lsu_addr_i;
`else
  function automatic logic [31:0] align_addr(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      2'd1:    return {addr[31:1], 1'b0};
      2'd3:    return {addr[31:2], 2'b00};
      default: return addr;
    endcase
  endfunction

  assign mis_chk  = 1'b0;
  assign addr_eff = align_addr(lsu_size_i, lsu_addr_i);
`endif

  assign rng_chk = out_of_range(lsu_size_i, lsu_addr_i);
  assign fault   = mis_chk | rng_chk;
  assign accept  = (state == IDLE) && lsu_valid_i;

  // Stage p0: request capture at acceptance; p1: load response capture in RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      store_p0     <= 1'b0;
      size_p0      <= 2'd0;
      uns_p0       <= 1'b0;
      addr_p0      <= '0;
      wr_data_p0   <= '0;
      rd_idx_p0    <= '0;
      mis_p0       <= 1'b0;
      rng_p0       <= 1'b0;
      load_data_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        store_p0   <= lsu_store_i;
        size_p0    <= lsu_size_i;
        uns_p0     <= lsu_unsigned_i;
        addr_p0    <= addr_eff;
        wr_data_p0 <= lsu_wr_data_i;
        rd_idx_p0  <= lsu_rd_idx_i;
        mis_p0     <= mis_chk;
        rng_p0     <= rng_chk;
        if (fault && !lsu_store_i) load_data_p1 <= '0;
      end
      if (state == RESP) load_data_p1 <= data_mem_rd_data_i;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (lsu_valid_i) state_nxt = fault ? DONE : REQ;
      REQ:  state_nxt = store_p0 ? DONE : RESP;
      RESP: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory port is live only in REQ/RESP so the memory sees zeros otherwise
  always_comb begin
    mem_active            = (state == REQ) || (state == RESP);
    lsu_ready_o           = (state == IDLE);
    lsu_done_o            = (state == DONE);
    lsu_rd_we_o           = (state == DONE) && !store_p0 && !mis_p0 && !rng_p0;
    lsu_misalign_o        = (state == DONE) && mis_p0;
    lsu_range_o           = (state == DONE) && rng_p0;
    lsu_load_data_o       = load_data_p1;
    lsu_rd_idx_o          = rd_idx_p0;
    data_mem_req_o        = mem_active;
    data_mem_addr_o       = mem_active ? addr_p0 : '0;
    data_mem_byte_en_o    = mem_active ? size_p0 : 2'd0;
    data_mem_wr_o         = (state == REQ) && store_p0;
    data_mem_wr_data_o    = mem_active ? wr_data_p0 : '0;
    data_mem_zero_extnd_o = mem_active && uns_p0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte-addressed memory model.
module tb_load_store_unit;

  localparam int unsigned DMEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_valid_i, lsu_ready_o, lsu_store_i, lsu_unsigned_i;
  logic [1:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wr_data_i, lsu_load_data_o;
  logic [4:0]  lsu_rd_idx_i, lsu_rd_idx_o;
  logic        lsu_done_o, lsu_rd_we_o, lsu_misalign_o, lsu_range_o;
  logic        data_mem_req_o, data_mem_wr_o, data_mem_zero_extnd_o;
  logic [31:0] data_mem_addr_o, data_mem_wr_data_o;
  logic [1:0]  data_mem_byte_en_o;
  logic [31:0] data_mem_rd_data_i = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic [1:0]  wr_be;
  logic [31:0] last_addr;
  logic [7:0]  mem [0:DMEM_WORDS*4-1];

  load_store_unit #(.DMEM_WORDS(DMEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_store_i(lsu_store_i),
    .lsu_size_i(lsu_size_i), .lsu_unsigned_i(lsu_unsigned_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wr_data_i(lsu_wr_data_i), .lsu_rd_idx_i(lsu_rd_idx_i), .lsu_done_o(lsu_done_o),
    .lsu_load_data_o(lsu_load_data_o), .lsu_rd_idx_o(lsu_rd_idx_o), .lsu_rd_we_o(lsu_rd_we_o),
    .lsu_misalign_o(lsu_misalign_o), .lsu_range_o(lsu_range_o),
    .data_mem_req_o(data_mem_req_o), .data_mem_addr_o(data_mem_addr_o),
    .data_mem_byte_en_o(data_mem_byte_en_o), .data_mem_wr_o(data_mem_wr_o),
    .data_mem_wr_data_o(data_mem_wr_data_o), .data_mem_zero_extnd_o(data_mem_zero_extnd_o),
    .data_mem_rd_data_i(data_mem_rd_data_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [1:0] be, input logic z);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[a[11:0]];
    b1 = mem[a[11:0] + 12'd1];
    b2 = mem[a[11:0] + 12'd2];
    b3 = mem[a[11:0] + 12'd3];
    case (be)
      2'd0:    return {{24{~z & b0[7]}}, b0};
      2'd1:    return {{16{~z & b1[7]}}, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  // Memory model: writes on the strobe, registered extended read data, zero outside requests
  always @(posedge clk) begin
    if (data_mem_req_o) begin
      req_cnt++;
      last_addr = data_mem_addr_o;
    end
    if (lsu_done_o) done_cnt++;
    if (data_mem_req_o && data_mem_wr_o) begin
      wr_cnt++;
      wr_be = data_mem_byte_en_o;
      mem[data_mem_addr_o[11:0]] = data_mem_wr_data_o[7:0];
      if (data_mem_byte_en_o != 2'd0) mem[data_mem_addr_o[11:0] + 12'd1] = data_mem_wr_data_o[15:8];
      if (data_mem_byte_en_o == 2'd3) begin
        mem[data_mem_addr_o[11:0] + 12'd2] = data_mem_wr_data_o[23:16];
        mem[data_mem_addr_o[11:0] + 12'd3] = data_mem_wr_data_o[31:24];
      end
    end
    if (data_mem_req_o && !data_mem_wr_o)
      data_mem_rd_data_i <= mem_read(data_mem_addr_o, data_mem_byte_en_o, data_mem_zero_extnd_o);
    else
      data_mem_rd_data_i <= '0;
  end

  task automatic send(input logic st, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    req_cnt = 0; wr_cnt = 0;
    lsu_valid_i = 1'b1; lsu_store_i = st; lsu_size_i = sz; lsu_unsigned_i = uns;
    lsu_addr_i = a; lsu_wr_data_i = wd; lsu_rd_idx_i = rd;
    @(posedge clk); #1;
    lsu_valid_i = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!lsu_done_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) step();
    n_checks++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", lsu_ready_o); end
    n_checks++;
    if ({lsu_done_o, lsu_rd_we_o, lsu_misalign_o, lsu_range_o, data_mem_req_o, data_mem_wr_o, data_mem_zero_extnd_o} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0", {lsu_done_o, lsu_rd_we_o, lsu_misalign_o, lsu_range_o, data_mem_req_o, data_mem_wr_o, data_mem_zero_extnd_o});
    end
    n_checks++;
    if ({lsu_load_data_o, lsu_rd_idx_o, data_mem_addr_o, data_mem_wr_data_o, data_mem_byte_en_o} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%h want 0", lsu_load_data_o, lsu_rd_idx_o, data_mem_addr_o);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_store_load_word;
    int lat;
    send(1'b1, 2'd3, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
    wait_done(lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", lat); end
    n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL sw_wr_pulses: got %0d want 1", wr_cnt); end
    n_checks++; if (lsu_rd_we_o !== 1'b0) begin n_fail++; $display("FAIL sw_rd_we: got %b want 0", lsu_rd_we_o); end
    step();
    send(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 5'd7);
    wait_done(lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL lw_latency: got %0d want 3", lat); end
    n_checks++; if (lsu_load_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", lsu_load_data_o); end
    n_checks++; if (lsu_rd_we_o !== 1'b1) begin n_fail++; $display("FAIL lw_rd_we: got %b want 1", lsu_rd_we_o); end
    n_checks++; if (lsu_rd_idx_o !== 5'd7) begin n_fail++; $display("FAIL lw_rd_idx: got %0d want 7", lsu_rd_idx_o); end
    n_checks++; if (wr_cnt !== 0 || req_cnt !== 2) begin n_fail++; $display("FAIL lw_mem_cycles: got wr=%0d req=%0d want wr=0 req=2", wr_cnt, req_cnt); end
    step();
  endtask

  task automatic test_load_extend;
    int lat;
    logic [1:0]  sz  [3] = '{2'd0, 2'd0, 2'd1};
    logic        uns [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] adr [3] = '{32'h13, 32'h13, 32'h12};
    logic [31:0] exp [3] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD};
    for (int i = 0; i < 3; i++) begin
      send(1'b0, sz[i], uns[i], adr[i], 32'h0, 5'd4);
      wait_done(lat);
      n_checks++; if (lsu_load_data_o !== exp[i]) begin n_fail++; $display("FAIL ld_extend_%0d: got %h want %h", i, lsu_load_data_o, exp[i]); end
      step();
    end
    repeat (2) step();
    n_checks++; if (lsu_load_data_o !== 32'hFFFFDEAD) begin n_fail++; $display("FAIL ld_hold: got %h want ffffdead", lsu_load_data_o); end
  endtask

  task automatic test_store_byte;
    int lat;
    send(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000005A, 5'd0);
    wait_done(lat);
    n_checks++; if (wr_be !== 2'd0 || wr_cnt !== 1) begin n_fail++; $display("FAIL sb_byte_en: got be=%0d wr=%0d want be=0 wr=1", wr_be, wr_cnt); end
    step();
    send(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 5'd2);
    wait_done(lat);
    n_checks++; if (lsu_load_data_o !== 32'h00005A00) begin n_fail++; $display("FAIL sb_readback: got %h want 00005a00", lsu_load_data_o); end
    step();
  endtask

  task automatic test_misalign;
    int lat;
    send(1'b0, 2'd1, 1'b1, 32'h11, 32'h0, 5'd3);
    wait_done(lat);
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL mis_latency: got %0d want 1", lat); end
    n_checks++; if (lsu_misalign_o !== 1'b1 || lsu_rd_we_o !== 1'b0) begin n_fail++; $display("FAIL mis_flags: got mis=%b we=%b want 1/0", lsu_misalign_o, lsu_rd_we_o); end
    n_checks++; if (req_cnt !== 0) begin n_fail++; $display("FAIL mis_no_req: got %0d want 0", req_cnt); end
    n_checks++; if (lsu_load_data_o !== 32'h0) begin n_fail++; $display("FAIL mis_data: got %h want 0", lsu_load_data_o); end
`else
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL mis_latency: got %0d want 3", lat); end
    n_checks++; if (lsu_misalign_o !== 1'b0 || lsu_rd_we_o !== 1'b1) begin n_fail++; $display("FAIL mis_flags: got mis=%b we=%b want 0/1", lsu_misalign_o, lsu_rd_we_o); end
    n_checks++; if (last_addr !== 32'h10) begin n_fail++; $display("FAIL mis_aligned_addr: got %h want 10", last_addr); end
    n_checks++; if (lsu_load_data_o !== 32'h0000BEEF) begin n_fail++; $display("FAIL mis_data: got %h want 0000beef", lsu_load_data_o); end
`endif
    step();
    send(1'b0, 2'd3, 1'b0, 32'h13, 32'h0, 5'd3);
    wait_done(lat);
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++; if (lsu_misalign_o !== 1'b1 || req_cnt !== 0) begin n_fail++; $display("FAIL mis_word: got mis=%b req=%0d want 1/0", lsu_misalign_o, req_cnt); end
`else
    n_checks++; if (lsu_load_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mis_word: got %h want deadbeef", lsu_load_data_o); end
`endif
    step();
  endtask

  task automatic test_range;
    int lat;
    send(1'b0, 2'd3, 1'b0, 32'h1000, 32'h0, 5'd5);
    wait_done(lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL rng_latency: got %0d want 1", lat); end
    n_checks++; if (lsu_range_o !== 1'b1 || lsu_rd_we_o !== 1'b0) begin n_fail++; $display("FAIL rng_flags: got rng=%b we=%b want 1/0", lsu_range_o, lsu_rd_we_o); end
    n_checks++; if (req_cnt !== 0 || lsu_load_data_o !== 32'h0) begin n_fail++; $display("FAIL rng_no_req: got req=%0d data=%h want 0/0", req_cnt, lsu_load_data_o); end
    step();
    send(1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, 5'd0);
    wait_done(lat);
    n_checks++; if (lsu_range_o !== 1'b1 || req_cnt !== 0) begin n_fail++; $display("FAIL rng_size2: got rng=%b req=%0d want 1/0", lsu_range_o, req_cnt); end
    step();
    send(1'b0, 2'd3, 1'b0, 32'h1001, 32'h0, 5'd5);
    wait_done(lat);
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++; if ({lsu_misalign_o, lsu_range_o} !== 2'b11) begin n_fail++; $display("FAIL rng_both: got %b want 11", {lsu_misalign_o, lsu_range_o}); end
`else
    n_checks++; if ({lsu_misalign_o, lsu_range_o} !== 2'b01) begin n_fail++; $display("FAIL rng_both: got %b want 01", {lsu_misalign_o, lsu_range_o}); end
`endif
    step();
    send(1'b0, 2'd3, 1'b0, 32'hFFC, 32'h0, 5'd5);
    wait_done(lat);
    n_checks++; if (lat !== 3 || lsu_range_o !== 1'b0 || lsu_rd_we_o !== 1'b1) begin n_fail++; $display("FAIL rng_top_word: got lat=%0d rng=%b we=%b want 3/0/1", lat, lsu_range_o, lsu_rd_we_o); end
    step();
  endtask

  task automatic test_reset_mid;
    int lat, d0;
    send(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 5'd9);
    step();
    n_checks++; if (data_mem_req_o !== 1'b1 || lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_resp: got req=%b rdy=%b want 1/0", data_mem_req_o, lsu_ready_o); end
    d0 = done_cnt;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (lsu_ready_o !== 1'b1 || data_mem_req_o !== 1'b0 || lsu_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got rdy=%b req=%b done=%b want 1/0/0", lsu_ready_o, data_mem_req_o, lsu_done_o); end
    n_checks++; if (lsu_load_data_o !== 32'h0 || lsu_rd_idx_o !== 5'd0 || lsu_rd_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_data: got %h/%0d/%b want 0", lsu_load_data_o, lsu_rd_idx_o, lsu_rd_we_o); end
    repeat (3) step();
    n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_cnt - d0); end
    send(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 5'd9);
    wait_done(lat);
    n_checks++; if (lat !== 3 || lsu_load_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rst_mid_recover: got lat=%0d data=%h want 3/deadbeef", lat, lsu_load_data_o); end
    step();
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = done_cnt;
    req_cnt = 0; wr_cnt = 0;
    lsu_valid_i = 1'b1; lsu_store_i = 1'b1; lsu_size_i = 2'd3; lsu_unsigned_i = 1'b0;
    lsu_addr_i = 32'h40; lsu_wr_data_i = 32'hCAFEF00D; lsu_rd_idx_i = 5'd0;
    repeat (6) step();
    lsu_valid_i = 1'b0;
    n_checks++; if (wr_cnt !== 2 || done_cnt - d0 !== 2) begin n_fail++; $display("FAIL b2b_spacing: got wr=%0d done=%0d want 2/2", wr_cnt, done_cnt - d0); end
    n_checks++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got rdy=%b want 1", lsu_ready_o); end
  endtask

  initial begin
    for (int i = 0; i < DMEM_WORDS * 4; i++) mem[i] = 8'h00;
    lsu_valid_i = 1'b0; lsu_store_i = 1'b0; lsu_size_i = 2'd0; lsu_unsigned_i = 1'b0;
    lsu_addr_i = '0; lsu_wr_data_i = '0; lsu_rd_idx_i = '0;
    wr_be = 2'd0; last_addr = '0;
    test_reset();
    test_store_load_word();
    test_load_extend();
    test_store_byte();
    test_misalign();
    test_range();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
